// File: rtl/mm3_seq_ctrl.sv
// Sequencing controller for a 3x3 output-stationary systolic matrix array.
// Latches operands, clears the array, feeds skewed streams, captures results.
module mm3_seq_ctrl #(
   parameter int data_size = 8,
   parameter int drain_cyc = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [9*data_size-1:0]       a_flat,
   input  logic [9*data_size-1:0]       b_flat,
   output logic                         busy,
   output logic                         done,
   output logic                         arr_reset,
   output logic [data_size-1:0]         a1,
   output logic [data_size-1:0]         a2,
   output logic [data_size-1:0]         a3,
   output logic [data_size-1:0]         b1,
   output logic [data_size-1:0]         b2,
   output logic [data_size-1:0]         b3,
   input  logic [2*data_size:0]         c1,
   input  logic [2*data_size:0]         c2,
   input  logic [2*data_size:0]         c3,
   input  logic [2*data_size:0]         c4,
   input  logic [2*data_size:0]         c5,
   input  logic [2*data_size:0]         c6,
   input  logic [2*data_size:0]         c7,
   input  logic [2*data_size:0]         c8,
   input  logic [2*data_size:0]         c9,
   output logic [9*(2*data_size+1)-1:0] c_flat
);

   localparam int DW  = data_size;
   localparam int DCW = (drain_cyc > 1) ? $clog2(drain_cyc) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [2:0]                   r_step;
   logic [2:0]                   w_step_nxt;
   logic [DCW-1:0]               r_drn;
   logic [DCW-1:0]               w_drn_nxt;
   logic                         w_load;
   logic                         w_cap;
   logic [9*DW-1:0]              r_a;
   logic [9*DW-1:0]              r_b;
   logic [2:0][DW-1:0]           r_ao;
   logic [2:0][DW-1:0]           r_bo;
   logic [2:0][DW-1:0]           w_ao_nxt;
   logic [2:0][DW-1:0]           w_bo_nxt;
   logic [9*(2*DW+1)-1:0]        r_c;

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_drn_nxt   = r_drn;
      w_load      = 1'b0;
      w_cap       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = CLR;
            end
         end
         CLR: begin
            w_state_nxt = FEED;
            w_step_nxt  = 3'd0;
         end
         FEED: begin
            if (r_step == 3'd6) begin
               w_state_nxt = DRAIN;
               w_drn_nxt   = '0;
            end else begin
               w_step_nxt = r_step + 3'd1;
            end
         end
         DRAIN: begin
            if (r_drn == DCW'(drain_cyc - 1)) begin
               w_cap       = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_drn_nxt = r_drn + 1'b1;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Streams are registered, so they are selected from the upcoming step.
   always_comb begin
      w_ao_nxt = '0;
      w_bo_nxt = '0;
      if (w_state_nxt == FEED) begin
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               if (w_step_nxt == 3'(r + k)) begin
                  w_ao_nxt[r] = r_a[DW*(3*r+k) +: DW];
                  w_bo_nxt[r] = r_b[DW*(3*k+r) +: DW];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_drn   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_ao    <= '0;
         r_bo    <= '0;
         r_c     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_drn   <= w_drn_nxt;
         r_ao    <= w_ao_nxt;
         r_bo    <= w_bo_nxt;
         if (w_load) begin
            r_a <= a_flat;
            r_b <= b_flat;
         end
         if (w_cap) begin
            r_c <= {c9, c8, c7, c6, c5, c4, c3, c2, c1};
         end
      end
   end

   assign busy      = (r_state == CLR) || (r_state == FEED) ||
                      (r_state == DRAIN);
   assign done      = (r_state == DONE);
   assign arr_reset = reset && (r_state != CLR);
   assign a1        = r_ao[0];
   assign a2        = r_ao[1];
   assign a3        = r_ao[2];
   assign b1        = r_bo[0];
   assign b2        = r_bo[1];
   assign b3        = r_bo[2];
   assign c_flat    = r_c;

endmodule

// File: tb/tb_mm3_seq_ctrl.sv
// Bench for mm3_seq_ctrl: behavioural 3x3 systolic array plus job scoreboard.
// Expected results and cycle timing come from operand math and the job timeline.
module tb_mm3_seq_ctrl;

   localparam int DW = 8;
   localparam int CW = 17;
   localparam int TW = 153;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [71:0]     a_flat = '0;
   logic [71:0]     b_flat = '0;
   logic            busy, done, arr_reset;
   logic [DW-1:0]   a1, a2, a3, b1, b2, b3;
   logic [CW-1:0]   pc [3][3];
   logic [TW-1:0]   c_flat;

   int tot = 0;
   int bad = 0;
   int cnt = 0;

   always #5 clk = ~clk;

   mm3_seq_ctrl #(.data_size(8), .drain_cyc(2)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a_flat(a_flat), .b_flat(b_flat),
      .busy(busy), .done(done), .arr_reset(arr_reset),
      .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
      .c1(pc[0][0]), .c2(pc[0][1]), .c3(pc[0][2]),
      .c4(pc[1][0]), .c5(pc[1][1]), .c6(pc[1][2]),
      .c7(pc[2][0]), .c8(pc[2][1]), .c9(pc[2][2]),
      .c_flat(c_flat)
   );

   // Array model: each PE forwards a/b one cycle and accumulates a*b.
   logic [DW-1:0] pa [3][3];
   logic [DW-1:0] pb [3][3];
   logic [DW-1:0] wa [3][4];
   logic [DW-1:0] wb [4][3];

   always_comb begin
      wa[0][0] = a1;
      wa[1][0] = a2;
      wa[2][0] = a3;
      wb[0][0] = b1;
      wb[0][1] = b2;
      wb[0][2] = b3;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            wa[i][j+1] = pa[i][j];
            wb[i+1][j] = pb[i][j];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (!arr_reset) begin
               pa[i][j] <= '0;
               pb[i][j] <= '0;
               pc[i][j] <= '0;
            end else begin
               pa[i][j] <= wa[i][j];
               pb[i][j] <= wb[i][j];
               pc[i][j] <= pc[i][j] + CW'(wa[i][j]) * CW'(wb[i][j]);
            end
         end
      end
   end

   always @(posedge clk) cnt <= cnt + 1;

   typedef struct {
      logic [71:0]   a;
      logic [71:0]   b;
      logic [TW-1:0] c;
      int            done_at;
   } job_t;

   job_t          q[$];
   int            free_at = 0;
   int            jobs = 0;
   logic [TW-1:0] exp_c = '0;
   bit            mh;
   int            me;
   int            fs;
   logic [23:0]   ea, eb;

   task automatic chk(input string tag, input logic [TW-1:0] got,
                      input logic [TW-1:0] exp);
      tot++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] mmul(input logic [71:0] a,
                                          input logic [71:0] b);
      logic [TW-1:0] r;
      logic [CW-1:0] s;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            s = '0;
            for (int k = 0; k < 3; k++)
               s = s + CW'(a[DW*(3*i+k) +: DW]) * CW'(b[DW*(3*k+j) +: DW]);
            r[CW*(3*i+j) +: CW] = s;
         end
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] fa(input logic [71:0] m,
                                        input int s, input int r);
      int d = s - r;
      if (d >= 0 && d <= 2) return m[DW*(3*r+d) +: DW];
      return '0;
   endfunction

   function automatic logic [DW-1:0] fb(input logic [71:0] m,
                                        input int s, input int c);
      int d = s - c;
      if (d >= 0 && d <= 2) return m[DW*(3*d+c) +: DW];
      return '0;
   endfunction

   // Monitor: checks interval cnt, then predicts what edge cnt+1 does.
   initial forever begin
      @(negedge clk);
      mh = (q.size() != 0);
      me = mh ? q[0].done_at - 10 : -100;
      fs = cnt - me - 1;
      ea = '0;
      eb = '0;
      if (mh && fs >= 0 && fs <= 6) begin
         ea = {fa(q[0].a, fs, 2), fa(q[0].a, fs, 1), fa(q[0].a, fs, 0)};
         eb = {fb(q[0].b, fs, 2), fb(q[0].b, fs, 1), fb(q[0].b, fs, 0)};
      end
      chk("a_stream", TW'({a3, a2, a1}), TW'(ea));
      chk("b_stream", TW'({b3, b2, b1}), TW'(eb));
      chk("busy", TW'(busy), TW'(mh && cnt >= me && cnt <= me + 9));
      chk("done", TW'(done), TW'(mh && cnt == me + 10));
      chk("arr_reset", TW'(arr_reset), TW'(reset && !(mh && cnt == me)));
      if (mh && cnt == me + 10) begin
         exp_c = q[0].c;
         q.pop_front();
      end
      chk("c_flat", c_flat, exp_c);
      if (!reset) begin
         q.delete();
         free_at = cnt + 2;
         exp_c = '0;
      end else if (start && cnt + 1 >= free_at) begin
         q.push_back('{a_flat, b_flat, mmul(a_flat, b_flat), cnt + 11});
         free_at = cnt + 13;
         jobs++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_job(input logic [71:0] a, input logic [71:0] b);
      a_flat = a;
      b_flat = b;
      start = 1'b1;
      step();
      start = 1'b0;
      a_flat = 72'({$urandom(), $urandom(), $urandom()});
      b_flat = 72'({$urandom(), $urandom(), $urandom()});
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      chk("timeout", TW'(n >= 60), TW'(0));
      repeat (2) step();
   endtask

   logic [71:0] ma, mb;
   int          j0;

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();

      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            ma[DW*(3*r+c) +: DW] = (r == c) ? 8'd1 : 8'd0;
            mb[DW*(3*r+c) +: DW] = DW'(3*r + c + 1);
         end
      run_job(ma, mb);
      wait_idle();
      for (int i = 0; i < 9; i++)
         chk("ident_c", TW'(c_flat[CW*i +: CW]), TW'(i + 1));

      for (int k = 0; k < 9; k++) begin
         ma[DW*k +: DW] = DW'(k + 1);
         mb[DW*k +: DW] = DW'(k + 10);
      end
      run_job(ma, mb);
      repeat (3) step();
      chk("skew_a", TW'({a3, a2, a1}), TW'({8'd7, 8'd5, 8'd3}));
      chk("skew_b", TW'({b3, b2, b1}), TW'({8'd12, 8'd14, 8'd16}));
      wait_idle();
      chk("skew_c00", TW'(c_flat[0 +: CW]), TW'(84));
      chk("skew_c01", TW'(c_flat[CW +: CW]), TW'(90));
      chk("skew_c02", TW'(c_flat[2*CW +: CW]), TW'(96));

      run_job({72{1'b1}}, {72{1'b1}});
      wait_idle();
      for (int i = 0; i < 9; i++)
         chk("wrap_c", TW'(c_flat[CW*i +: CW]), TW'(64003));

      j0 = jobs;
      a_flat = 72'({$urandom(), $urandom(), $urandom()});
      b_flat = 72'({$urandom(), $urandom(), $urandom()});
      start = 1'b1;
      step();
      a_flat = 72'({$urandom(), $urandom(), $urandom()});
      b_flat = 72'({$urandom(), $urandom(), $urandom()});
      repeat (12) step();
      start = 1'b0;
      wait_idle();
      chk("held_jobs", TW'(jobs - j0), TW'(2));

      j0 = jobs;
      run_job(72'({$urandom(), $urandom(), $urandom()}),
              72'({$urandom(), $urandom(), $urandom()}));
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle();
      chk("feed_start_jobs", TW'(jobs - j0), TW'(1));

      run_job(72'({$urandom(), $urandom(), $urandom()}),
              72'({$urandom(), $urandom(), $urandom()}));
      repeat (4) step();
      reset = 1'b0;
      step();
      chk("rst_busy", TW'(busy), TW'(0));
      chk("rst_cflat", c_flat, TW'(0));
      step();
      reset = 1'b1;
      step();
      chk("rst_q", TW'(q.size()), TW'(0));
      for (int k = 0; k < 9; k++) begin
         ma[DW*k +: DW] = DW'(9 - k);
         mb[DW*k +: DW] = DW'(2 * k + 1);
      end
      run_job(ma, mb);
      wait_idle();
      chk("post_rst_c", c_flat, mmul(ma, mb));
      chk("q_end", TW'(q.size()), TW'(0));

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

endmodule
